// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: IF/ID/EXE/MEM/WB sequencing with a MemReq/MemRdy wait timeout.
// Optional macro CTRL_TRAP_EN: an undefined instruction halts in TRAP instead of acting as a NOP.
module multicycle_ctrl #(
   parameter int WAIT_LIMIT = 255,
   parameter int CNT_W      = 8
) (
   input  logic       i_Clk,
   input  logic       i_Clrn,
   input  logic [5:0] i_Op,
   input  logic [5:0] i_Func,
   input  logic       i_Z,
   input  logic       i_MemRdy,
   output logic       o_MemReq,
   output logic       o_Iord,
   output logic       o_Wir,
   output logic       o_Wpc,
   output logic [1:0] o_Pcsrc,
   output logic       o_Se,
   output logic       o_Alusrca,
   output logic [1:0] o_Alusrcb,
   output logic [3:0] o_Aluc,
   output logic       o_Wreg,
   output logic       o_Regrt,
   output logic       o_M2reg,
   output logic       o_Jal,
   output logic       o_Wmem,
   output logic       o_MemErr,
   output logic       o_Trap,
   output logic [2:0] o_State
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EXE  = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_TRAP = 3'd5
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                          ALU_XOR = 4'd4, ALU_LUI = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7,
                          ALU_SRA = 4'd8;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_waitCnt;

   logic w_isR, w_isJ, w_isJal, w_isJr, w_isBeq, w_isBne, w_isLw, w_isSw, w_isIalu;
   logic w_rAluOk, w_legal, w_se, w_memState, w_timeout;
   logic [3:0] w_rAluc, w_iAluc;

   assign w_isR   = (i_Op == 6'b000000);
   assign w_isJ   = (i_Op == 6'b000010);
   assign w_isJal = (i_Op == 6'b000011);
   assign w_isBeq = (i_Op == 6'b000100);
   assign w_isBne = (i_Op == 6'b000101);
   assign w_isLw  = (i_Op == 6'b100011);
   assign w_isSw  = (i_Op == 6'b101011);
   assign w_isJr  = w_isR && (i_Func == 6'b001000);
   assign w_se    = w_isBeq | w_isBne | w_isLw | w_isSw |
                    (i_Op == 6'b001000) | (i_Op == 6'b001001);
   assign w_legal = w_isJ | w_isJal | w_isJr | w_isBeq | w_isBne | w_isLw | w_isSw |
                    w_isIalu | (w_isR & w_rAluOk);

   // ALU operation decode for R-type (by Func) and I-type (by Op)
   always_comb begin
      w_rAluOk = 1'b1;
      w_rAluc  = ALU_ADD;
      case (i_Func)
         6'b100000, 6'b100001: w_rAluc = ALU_ADD;
         6'b100010, 6'b100011: w_rAluc = ALU_SUB;
         6'b100100:            w_rAluc = ALU_AND;
         6'b100101:            w_rAluc = ALU_OR;
         6'b100110:            w_rAluc = ALU_XOR;
         6'b000000:            w_rAluc = ALU_SLL;
         6'b000010:            w_rAluc = ALU_SRL;
         6'b000011:            w_rAluc = ALU_SRA;
         default:              w_rAluOk = 1'b0;
      endcase
      w_isIalu = 1'b1;
      w_iAluc  = ALU_ADD;
      case (i_Op)
         6'b001000, 6'b001001: w_iAluc = ALU_ADD;
         6'b001100:            w_iAluc = ALU_AND;
         6'b001101:            w_iAluc = ALU_OR;
         6'b001110:            w_iAluc = ALU_XOR;
         6'b001111:            w_iAluc = ALU_LUI;
         default:              w_isIalu = 1'b0;
      endcase
   end

   assign w_memState = (r_state == S_IF) || (r_state == S_MEM);
   assign w_timeout  = (WAIT_LIMIT != 0) && w_memState && !i_MemRdy &&
                       (r_waitCnt == CNT_W'(WAIT_LIMIT));

   // Mealy outputs and next state; a timeout suppresses every strobe and refetches
   always_comb begin
      w_next    = r_state;
      o_State   = r_state;
      o_Se      = w_se;
      o_MemReq  = 1'b0;
      o_Iord    = 1'b0;
      o_Wir     = 1'b0;
      o_Wpc     = 1'b0;
      o_Pcsrc   = 2'd0;
      o_Alusrca = 1'b0;
      o_Alusrcb = 2'd0;
      o_Aluc    = ALU_ADD;
      o_Wreg    = 1'b0;
      o_Regrt   = 1'b0;
      o_M2reg   = 1'b0;
      o_Jal     = 1'b0;
      o_Wmem    = 1'b0;
      o_MemErr  = 1'b0;
      o_Trap    = 1'b0;
      case (r_state)
         S_IF: begin
            if (w_timeout) begin
               o_MemErr = 1'b1;
               w_next   = S_IF;
            end else begin
               o_MemReq  = 1'b1;
               o_Alusrcb = 2'd1;
               if (i_MemRdy) begin
                  o_Wir  = 1'b1;
                  o_Wpc  = 1'b1;
                  w_next = S_ID;
               end
            end
         end
         S_ID: begin
            o_Alusrcb = 2'd3;
            if (w_isJ || w_isJal) begin
               o_Wpc   = 1'b1;
               o_Pcsrc = 2'd3;
               o_Wreg  = w_isJal;
               o_Jal   = w_isJal;
               w_next  = S_IF;
            end else if (w_isJr) begin
               o_Wpc   = 1'b1;
               o_Pcsrc = 2'd2;
               w_next  = S_IF;
            end else if (w_legal) begin
               w_next = S_EXE;
            end else begin
`ifdef CTRL_TRAP_EN
               w_next = S_TRAP;
`else
               w_next = S_IF;
`endif
            end
         end
         S_EXE: begin
            o_Alusrca = 1'b1;
            if (w_isBeq || w_isBne) begin
               o_Aluc  = ALU_SUB;
               o_Wpc   = w_isBeq ? i_Z : ~i_Z;
               o_Pcsrc = 2'd1;
               w_next  = S_IF;
            end else if (w_isLw || w_isSw) begin
               o_Alusrcb = 2'd2;
               w_next    = S_MEM;
            end else if (w_isR) begin
               o_Aluc = w_rAluc;
               w_next = S_WB;
            end else begin
               o_Alusrcb = 2'd2;
               o_Aluc    = w_iAluc;
               w_next    = S_WB;
            end
         end
         S_MEM: begin
            if (w_timeout) begin
               o_MemErr = 1'b1;
               w_next   = S_IF;
            end else begin
               o_MemReq = 1'b1;
               o_Iord   = 1'b1;
               if (i_MemRdy) begin
                  o_Wmem = w_isSw;
                  w_next = w_isSw ? S_IF : S_WB;
               end
            end
         end
         S_WB: begin
            o_Wreg  = 1'b1;
            o_Regrt = w_isIalu | w_isLw;
            o_M2reg = w_isLw;
            w_next  = S_IF;
         end
         S_TRAP: begin
`ifdef CTRL_TRAP_EN
            o_Trap = 1'b1;
            w_next = S_TRAP;
`else
            w_next = S_IF;
`endif
         end
         default: w_next = S_IF;
      endcase
      if (!i_Clrn) begin
         o_State   = 3'd0;
         o_Se      = 1'b0;
         o_MemReq  = 1'b0;
         o_Iord    = 1'b0;
         o_Wir     = 1'b0;
         o_Wpc     = 1'b0;
         o_Pcsrc   = 2'd0;
         o_Alusrca = 1'b0;
         o_Alusrcb = 2'd0;
         o_Aluc    = 4'd0;
         o_Wreg    = 1'b0;
         o_Regrt   = 1'b0;
         o_M2reg   = 1'b0;
         o_Jal     = 1'b0;
         o_Wmem    = 1'b0;
         o_MemErr  = 1'b0;
         o_Trap    = 1'b0;
      end
   end

   // State register and wait counter; the counter restarts whenever an access ends
   always_ff @(posedge i_Clk) begin
      if (!i_Clrn) begin
         r_state   <= S_IF;
         r_waitCnt <= '0;
      end else begin
         r_state <= w_next;
         if ((w_next != r_state) || w_timeout)
            r_waitCnt <= '0;
         else if (w_memState && !i_MemRdy)
            r_waitCnt <= r_waitCnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expected traces built from instruction rules,
// a monitor compares every cycle's outputs against the queued expectation.
module tb_multicycle_ctrl;

   localparam int LIMIT = 6;

   typedef struct packed {
      logic [2:0] state;
      logic       memReq;
      logic       iord;
      logic       wir;
      logic       wpc;
      logic [1:0] pcsrc;
      logic       se;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [3:0] aluc;
      logic       wreg;
      logic       regrt;
      logic       m2reg;
      logic       jal;
      logic       wmem;
      logic       memErr;
      logic       trap;
   } outs_t;

   typedef struct {
      logic  clrn;
      logic  memRdy;
      outs_t exp;
   } step_t;

   typedef enum {K_RALU, K_IALU, K_J, K_JAL, K_JR, K_BEQ, K_BNE, K_LW, K_SW, K_ILL} kind_t;

   logic clk = 1'b0;
   logic Clrn, Z, MemRdy;
   logic [5:0] Op, Func;
   logic MemReq, Iord, Wir, Wpc, Se, Alusrca, Wreg, Regrt, M2reg, Jal, Wmem, MemErr, Trap;
   logic [1:0] Pcsrc, Alusrcb;
   logic [3:0] Aluc;
   logic [2:0] State;

   step_t trace[$];
   outs_t sb[$];
   int    checks = 0;
   int    errors = 0;
   logic  curZ;

   always #5 clk = ~clk;

   multicycle_ctrl #(.WAIT_LIMIT(LIMIT), .CNT_W(8)) dut (
      .i_Clk(clk), .i_Clrn(Clrn), .i_Op(Op), .i_Func(Func), .i_Z(Z), .i_MemRdy(MemRdy),
      .o_MemReq(MemReq), .o_Iord(Iord), .o_Wir(Wir), .o_Wpc(Wpc), .o_Pcsrc(Pcsrc),
      .o_Se(Se), .o_Alusrca(Alusrca), .o_Alusrcb(Alusrcb), .o_Aluc(Aluc), .o_Wreg(Wreg),
      .o_Regrt(Regrt), .o_M2reg(M2reg), .o_Jal(Jal), .o_Wmem(Wmem), .o_MemErr(MemErr),
      .o_Trap(Trap), .o_State(State)
   );

   function automatic logic seOf(input logic [5:0] op);
      return op inside {6'b001000, 6'b001001, 6'b100011, 6'b101011, 6'b000100, 6'b000101};
   endfunction

   function automatic kind_t kindOf(input logic [5:0] op, input logic [5:0] func,
                                    output logic [3:0] aluc);
      aluc = 4'd0;
      case (op)
         6'b000000: begin
            case (func)
               6'b100000, 6'b100001: aluc = 4'd0;
               6'b100010, 6'b100011: aluc = 4'd1;
               6'b100100: aluc = 4'd2;
               6'b100101: aluc = 4'd3;
               6'b100110: aluc = 4'd4;
               6'b000000: aluc = 4'd6;
               6'b000010: aluc = 4'd7;
               6'b000011: aluc = 4'd8;
               6'b001000: return K_JR;
               default:   return K_ILL;
            endcase
            return K_RALU;
         end
         6'b000010: return K_J;
         6'b000011: return K_JAL;
         6'b000100: return K_BEQ;
         6'b000101: return K_BNE;
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b001000, 6'b001001: begin aluc = 4'd0; return K_IALU; end
         6'b001100: begin aluc = 4'd2; return K_IALU; end
         6'b001101: begin aluc = 4'd3; return K_IALU; end
         6'b001110: begin aluc = 4'd4; return K_IALU; end
         6'b001111: begin aluc = 4'd5; return K_IALU; end
         default:   return K_ILL;
      endcase
   endfunction

   function automatic outs_t idle(input logic se, input logic [2:0] st);
      outs_t o;
      o       = '0;
      o.state = st;
      o.se    = se;
      return o;
   endfunction

   task automatic pushStep(input logic clrn, input logic memRdy, input outs_t exp);
      step_t s;
      s.clrn   = clrn;
      s.memRdy = memRdy;
      s.exp    = exp;
      trace.push_back(s);
   endtask

   task automatic pushReset();
      pushStep(1'b0, 1'($urandom_range(0, 1)), '0);
   endtask

   // One memory access: stalls, then either completion or a timeout after LIMIT stalls
   task automatic addAccess(input logic se, input logic [2:0] st, input int waits,
                            input outs_t stall, input outs_t done, output bit ok);
      outs_t t;
      int    n;
      n = (waits > LIMIT) ? LIMIT : waits;
      for (int i = 0; i < n; i++) pushStep(1'b1, 1'b0, stall);
      if (waits > LIMIT) begin
         t        = idle(se, st);
         t.memErr = 1'b1;
         pushStep(1'b1, 1'b0, t);
         ok = 1'b0;
      end else begin
         pushStep(1'b1, 1'b1, done);
         ok = 1'b1;
      end
   endtask

   task automatic buildInstr(input logic [5:0] op, input logic [5:0] func, input logic z,
                             input int wIf, input int wMem);
      logic [3:0] aluc;
      kind_t      k;
      logic       se;
      bit         ok;
      outs_t      a, b;
      se = seOf(op);
      k  = kindOf(op, func, aluc);
      a = idle(se, 3'd0); a.memReq = 1'b1; a.alusrcb = 2'd1;
      b = a; b.wir = 1'b1; b.wpc = 1'b1;
      addAccess(se, 3'd0, wIf, a, b, ok);
      if (!ok) return;
      a = idle(se, 3'd1); a.alusrcb = 2'd3;
      if (k == K_J || k == K_JAL) begin a.wpc = 1'b1; a.pcsrc = 2'd3; end
      if (k == K_JAL) begin a.wreg = 1'b1; a.jal = 1'b1; end
      if (k == K_JR) begin a.wpc = 1'b1; a.pcsrc = 2'd2; end
      pushStep(1'b1, 1'($urandom_range(0, 1)), a);
      if (k inside {K_J, K_JAL, K_JR}) return;
      if (k == K_ILL) begin
`ifdef CTRL_TRAP_EN
         a = idle(se, 3'd5); a.trap = 1'b1;
         for (int i = 0; i < 3; i++) pushStep(1'b1, 1'($urandom_range(0, 1)), a);
         pushReset();
`endif
         return;
      end
      a = idle(se, 3'd2); a.alusrca = 1'b1;
      case (k)
         K_BEQ, K_BNE: begin
            a.aluc = 4'd1; a.pcsrc = 2'd1;
            a.wpc  = (k == K_BEQ) ? z : ~z;
         end
         K_LW, K_SW: a.alusrcb = 2'd2;
         K_RALU:     a.aluc = aluc;
         default: begin a.alusrcb = 2'd2; a.aluc = aluc; end
      endcase
      pushStep(1'b1, 1'($urandom_range(0, 1)), a);
      if (k == K_BEQ || k == K_BNE) return;
      if (k == K_LW || k == K_SW) begin
         a = idle(se, 3'd3); a.memReq = 1'b1; a.iord = 1'b1;
         b = a; b.wmem = (k == K_SW);
         addAccess(se, 3'd3, wMem, a, b, ok);
         if (!ok || k == K_SW) return;
      end
      a = idle(se, 3'd4); a.wreg = 1'b1;
      a.regrt = (k == K_IALU) || (k == K_LW);
      a.m2reg = (k == K_LW);
      pushStep(1'b1, 1'($urandom_range(0, 1)), a);
   endtask

   // Plays the queued trace one cycle per entry, publishing each expectation to the scoreboard
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] func);
      step_t s;
      Op   = op;
      Func = func;
      Z    = curZ;
      while (trace.size() > 0) begin
         s      = trace.pop_front();
         Clrn   = s.clrn;
         MemRdy = s.memRdy;
         sb.push_back(s.exp);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic runInstr(input logic [5:0] op, input logic [5:0] func, input logic z,
                           input int wIf, input int wMem, input int abortAt);
      curZ = z;
      buildInstr(op, func, z, wIf, wMem);
      if (abortAt >= 0 && abortAt < trace.size()) begin
         while (trace.size() > abortAt) void'(trace.pop_back());
         pushReset();
      end
      applyStimulus(op, func);
   endtask

   task automatic checkOutput(input outs_t exp);
      outs_t got;
      got = {State, MemReq, Iord, Wir, Wpc, Pcsrc, Se, Alusrca, Alusrcb, Aluc,
             Wreg, Regrt, M2reg, Jal, Wmem, MemErr, Trap};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL outputs check#%0d state=%0d got=%h expected=%h",
                  checks, exp.state, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) checkOutput(sb.pop_front());
   end

   logic [5:0] tblOp[25] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                             6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e,
                             6'h0f, 6'h23, 6'h2b, 6'h3f, 6'h01};
   logic [5:0] tblFn[11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03,
                             6'h08};

   initial begin
      int idx, wIf, wMem, ab;
      logic [5:0] op, fn;
      Clrn = 1'b0; MemRdy = 1'b0; Z = 1'b0; Op = '0; Func = '0; curZ = 1'b0;
      @(posedge clk);
      #1;
      pushReset();
      pushReset();
      applyStimulus(6'h00, 6'h20);
      runInstr(6'b001000, 6'h15, 1'b0, 0, 0, -1);
      runInstr(6'b001101, 6'h00, 1'b1, 0, 0, -1);
      runInstr(6'b000100, 6'h00, 1'b1, 0, 0, -1);
      runInstr(6'b000100, 6'h00, 1'b0, 0, 0, -1);
      runInstr(6'b000101, 6'h00, 1'b0, 1, 0, -1);
      runInstr(6'b100011, 6'h00, 1'b0, 0, 5, -1);
      runInstr(6'b100011, 6'h00, 1'b0, 0, LIMIT, -1);
      runInstr(6'b100011, 6'h00, 1'b0, 0, LIMIT + 1, -1);
      runInstr(6'b000000, 6'h22, 1'b0, LIMIT + 2, 0, -1);
      runInstr(6'b000011, 6'h00, 1'b0, 2, 0, -1);
      runInstr(6'b000000, 6'h08, 1'b1, 0, 0, -1);
      runInstr(6'b111111, 6'h00, 1'b0, 0, 0, -1);
      runInstr(6'b000000, 6'h3f, 1'b0, 0, 0, -1);
      runInstr(6'b101011, 6'h00, 1'b0, 0, 3, 4);
      runInstr(6'b101011, 6'h00, 1'b1, 0, 0, -1);
      for (int n = 0; n < 200; n++) begin
         idx = $urandom_range(0, 24);
         op  = tblOp[idx];
         fn  = (idx < 11) ? tblFn[idx] : 6'($urandom);
         if (op == 6'h00 && $urandom_range(0, 15) == 0) fn = 6'h3f;
         wIf  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, LIMIT + 2) : 0;
         wMem = ($urandom_range(0, 5) == 0) ? $urandom_range(0, LIMIT + 2) : 0;
         ab   = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 5) : -1;
         runInstr(op, fn, 1'($urandom_range(0, 1)), wIf, wMem, ab);
      end
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain pending=%0d required=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
